// File: rtl/ts_pack_pkg.sv
// Shared definitions for the transport-stream byte-to-word packer:
// routing-header layout, packer state encoding and a header field helper.
package ts_pack_pkg;

    // Fixed routing header ahead of every payload
    localparam int HDR_LEN = 10;

    // Header field layout: start byte index and length in bytes
    localparam int FLD_CHAN_START = 0;
    localparam int FLD_CHAN_LEN   = 1;
    localparam int FLD_PID_START  = 1;
    localparam int FLD_PID_LEN    = 2;
    localparam int FLD_PORT_START = 3;
    localparam int FLD_PORT_LEN   = 1;
    localparam int FLD_IP_START   = 4;
    localparam int FLD_IP_LEN     = 4;
    localparam int FLD_UDP_START  = 8;
    localparam int FLD_UDP_LEN    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    // True when the header byte at idx is the final byte of its field
    function automatic logic hdr_field_end(input logic [7:0] idx);
        return (idx == 8'(FLD_CHAN_START + FLD_CHAN_LEN - 1)) ||
               (idx == 8'(FLD_PID_START  + FLD_PID_LEN  - 1)) ||
               (idx == 8'(FLD_PORT_START + FLD_PORT_LEN - 1)) ||
               (idx == 8'(FLD_IP_START   + FLD_IP_LEN   - 1)) ||
               (idx == 8'(FLD_UDP_START  + FLD_UDP_LEN  - 1));
    endfunction

endpackage

// File: rtl/ts_byte_gather.sv
// Byte gather: accumulates bytes MSB-first into one DATA_W word.
// word_o/nbytes_o already include the byte presented this cycle, so the
// caller can register a completed word in the same cycle as its last byte.
// clear_i drops previous contents (the current byte, if valid, becomes lane 0);
// flush_i empties the gather after this cycle.
module ts_byte_gather
    import ts_pack_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_main,
    input  logic              rst,
    input  logic [7:0]        byte_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] word_o,
    output logic [3:0]        nbytes_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] acc_q, acc_d, base_w, merged_w;
    logic [3:0]        cnt_q, cnt_d, base_cnt;

    // Merge the incoming byte into its lane and compute the next gather contents
    always_comb begin
        base_w   = clear_i ? '0 : acc_q;
        base_cnt = clear_i ? '0 : cnt_q;
        merged_w = base_w;
        if (valid_i) begin
            for (int i = 0; i < NB; i++) begin
                if (base_cnt == 4'(i)) begin
                    merged_w[DATA_W-1-8*i -: 8] = byte_i;
                end
            end
        end
        word_o   = merged_w;
        nbytes_o = base_cnt + {3'b000, valid_i};
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (valid_i || clear_i) begin
            acc_d = merged_w;
            cnt_d = nbytes_o;
        end
    end

    // Gather register
    always_ff @(posedge clk_main) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ts_pkt_packer.sv
// Transport-stream packer: splits the 10-byte routing header into
// right-justified field words and packs the payload MSB-first into DATA_W
// words, with truncation / overlong detection.
// Optional statistics counters are built when TS_PACK_STATS_EN is defined.
//
// Handshake: ts_din_en qualifies ts_din (valid only, no ready); nothing moves
// while it is low. ts_dout_en qualifies ts_dout/last/nbytes for exactly one
// cycle; there is no backpressure and ts_dout/last/nbytes are zero when idle.
module ts_pkt_packer
    import ts_pack_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PAY_LEN = 188
) (
    input  logic              clk_main,
    input  logic              rst,
    input  logic [8:0]        ts_din,
    input  logic              ts_din_en,
    output logic [DATA_W:0]   ts_dout,
    output logic              ts_dout_en,
    output logic              ts_dout_last,
    output logic [3:0]        ts_dout_nbytes,
    output logic              err_trunc,
    output logic              err_long,
    output state_e            dbg_state_o
`ifdef TS_PACK_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       trunc_cnt,
    output logic [15:0]       long_cnt
`endif
);

    localparam int         NB       = DATA_W / 8;
    localparam logic [7:0] LAST_IDX = 8'(HDR_LEN + PAY_LEN - 1);
    localparam logic [7:0] LONG_IDX = 8'(HDR_LEN + PAY_LEN);
    localparam logic [7:0] HDR_END  = 8'(HDR_LEN - 1);

    state_e            state_q, state_d;
    logic [7:0]        idx_q, idx_d, byte_idx;
    logic [DATA_W:0]   dout_q, dout_d;
    logic              en_q, en_d, last_q, last_d;
    logic [3:0]        nb_q, nb_d;
    logic              etrunc_q, etrunc_d, elong_q, elong_d;

    logic              sop;
    logic              g_valid, g_flush, g_clear;
    logic [DATA_W-1:0] g_word, hdr_word;
    logic [3:0]        g_nbytes;

    assign sop = ts_din[8];

    ts_byte_gather #(.DATA_W(DATA_W)) u_gather (
        .clk_main (clk_main),
        .rst      (rst),
        .byte_i   (ts_din[7:0]),
        .valid_i  (g_valid),
        .flush_i  (g_flush),
        .clear_i  (g_clear),
        .word_o   (g_word),
        .nbytes_o (g_nbytes)
    );

    // Header fields leave the gather left-justified; shift them down to bit 0
    assign hdr_word = g_word >> (8 * (NB - int'(g_nbytes)));

    // Next-state, byte routing and registered-output selection
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        g_valid  = 1'b0;
        g_flush  = 1'b0;
        g_clear  = 1'b0;
        dout_d   = '0;
        en_d     = 1'b0;
        last_d   = 1'b0;
        nb_d     = '0;
        etrunc_d = 1'b0;
        elong_d  = 1'b0;
        byte_idx = sop ? 8'd0 : idx_q;
        if (ts_din_en) begin
            idx_d = (byte_idx == 8'hFF) ? 8'hFF : byte_idx + 8'd1;
            // A new SOP only counts as truncation if the old packet was unfinished
            if (sop) begin
                etrunc_d = (state_q == ST_HDR) ||
                           ((state_q == ST_PAY) && (idx_q < LONG_IDX));
            end
            if (sop || (state_q == ST_HDR)) begin
                g_valid = 1'b1;
                g_clear = sop;
                state_d = (byte_idx == HDR_END) ? ST_PAY : ST_HDR;
                if (hdr_field_end(byte_idx)) begin
                    g_flush = 1'b1;
                    en_d    = 1'b1;
                    dout_d  = {sop, hdr_word};
                    nb_d    = g_nbytes;
                end
            end else if (state_q == ST_PAY) begin
                if (byte_idx == LONG_IDX) begin
                    elong_d = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    g_valid = 1'b1;
                    if ((g_nbytes == 4'(NB)) || (byte_idx == LAST_IDX)) begin
                        g_flush = 1'b1;
                        en_d    = 1'b1;
                        dout_d  = {1'b0, g_word};
                        nb_d    = g_nbytes;
                        last_d  = (byte_idx == LAST_IDX);
                    end
                end
            end
        end
    end

    // State, byte index and output registers
    always_ff @(posedge clk_main) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dout_q   <= '0;
            en_q     <= 1'b0;
            last_q   <= 1'b0;
            nb_q     <= '0;
            etrunc_q <= 1'b0;
            elong_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dout_q   <= dout_d;
            en_q     <= en_d;
            last_q   <= last_d;
            nb_q     <= nb_d;
            etrunc_q <= etrunc_d;
            elong_q  <= elong_d;
        end
    end

    assign ts_dout        = dout_q;
    assign ts_dout_en     = en_q;
    assign ts_dout_last   = last_q;
    assign ts_dout_nbytes = nb_q;
    assign err_trunc      = etrunc_q;
    assign err_long       = elong_q;
    assign dbg_state_o    = state_q;

`ifdef TS_PACK_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d, trunc_cnt_q, trunc_cnt_d, long_cnt_q, long_cnt_d;

    // Saturating event counters; a clear wins over a same-cycle increment
    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        long_cnt_d  = long_cnt_q;
        if (stats_clr) begin
            pkt_cnt_d   = '0;
            trunc_cnt_d = '0;
            long_cnt_d  = '0;
        end else begin
            if (last_q && (pkt_cnt_q != 16'hFFFF))     pkt_cnt_d   = pkt_cnt_q + 16'd1;
            if (etrunc_q && (trunc_cnt_q != 16'hFFFF)) trunc_cnt_d = trunc_cnt_q + 16'd1;
            if (elong_q && (long_cnt_q != 16'hFFFF))   long_cnt_d  = long_cnt_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_main) begin
        if (rst) begin
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
            long_cnt_q  <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
            long_cnt_q  <= long_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
    assign long_cnt  = long_cnt_q;
`endif

endmodule
